// File: rtl/mic1_mem_arbiter_if.sv
// Bus bundle between the MIC-1 memory arbiter and its CPU, loader, memory and byte-I/O neighbours.
`default_nettype none

interface mic1_mem_arbiter_if;
  logic        cpu_run;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_hold;

  logic        ldr_req;
  logic        ldr_write;
  logic [31:0] ldr_addr;
  logic [31:0] ldr_wdata;
  logic        ldr_gnt;
  logic        ldr_rvalid;
  logic [31:0] ldr_rdata;

  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [7:0]  io_in_data;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [7:0]  io_out_data;
  logic        io_out_valid;

  modport slave (
    input  cpu_run, cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_hold,
    input  ldr_req, ldr_write, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output mem_ren, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata,
    input  io_in_data, io_in_valid,
    output io_in_ready, io_out_data, io_out_valid
  );

  modport master (
    output cpu_run, cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_hold,
    output ldr_req, ldr_write, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  mem_ren, mem_wen, mem_addr, mem_wdata,
    output mem_rdata,
    output io_in_data, io_in_valid,
    input  io_in_ready, io_out_data, io_out_valid
  );
endinterface

`default_nettype wire

// File: rtl/mic1_mem_arbiter.sv
// MIC-1 memory arbiter: CPU has absolute memory priority, loader gets idle cycles,
// one memory-mapped byte I/O port with a single-byte receive buffer.
`default_nettype none

module mic1_mem_arbiter #(
  parameter logic [31:0] IO_ADDR      = 32'hFFFF_FFFD,
  parameter int          STARVE_LIMIT = 16
) (
  input  wire logic           clk,
  input  wire logic           reset,
  mic1_mem_arbiter_if.slave   bus
);

  localparam logic [1:0] L_IDLE = 2'd0;
  localparam logic [1:0] L_WAIT = 2'd1;
  localparam logic [1:0] L_RESP = 2'd2;
  localparam logic [7:0] HOLD_LIMIT = 8'(STARVE_LIMIT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rx_full_q, rx_full_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        src_io_q, src_io_d;
  logic [31:0] io_rdata_q, io_rdata_d;

  logic        cpu_mem, cpu_io_rd, cpu_io_wr;
  logic        gnt, rvalid;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_wdata;

  assign cpu_mem   = bus.cpu_run & (bus.cpu_read | bus.cpu_write) & (bus.cpu_addr != IO_ADDR);
  assign cpu_io_rd = bus.cpu_run & bus.cpu_read  & (bus.cpu_addr == IO_ADDR);
  assign cpu_io_wr = bus.cpu_run & bus.cpu_write & (bus.cpu_addr == IO_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= L_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      L_IDLE: if (bus.ldr_req) state_d = L_WAIT;
      L_WAIT: begin
        if (!bus.ldr_req)  state_d = L_IDLE;
        else if (!cpu_mem) state_d = bus.ldr_write ? L_IDLE : L_RESP;
      end
      L_RESP:  state_d = L_IDLE;
      default: state_d = L_IDLE;
    endcase
  end

  // The loader only ever sees cycles the CPU leaves free; a held CPU still wins.
  always_comb begin
    gnt       = (state_q == L_WAIT) & bus.ldr_req & ~cpu_mem;
    rvalid    = (state_q == L_RESP);
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = bus.cpu_addr;
    mem_wdata = bus.cpu_wdata;
    if (cpu_mem) begin
      mem_ren = bus.cpu_read;
      mem_wen = bus.cpu_write;
    end else if (gnt) begin
      mem_ren   = ~bus.ldr_write;
      mem_wen   = bus.ldr_write;
      mem_addr  = bus.ldr_addr;
      mem_wdata = bus.ldr_wdata;
    end
  end

  always_comb begin
    cnt_d = 8'd0;
    if ((state_q == L_WAIT) && bus.ldr_req && !gnt)
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (bus.io_in_valid && !rx_full_q) begin
      rx_full_d = 1'b1;
      rx_byte_d = bus.io_in_data;
    end else if (cpu_io_rd) begin
      rx_full_d = 1'b0;
    end

    src_io_d   = cpu_io_rd;
    io_rdata_d = io_rdata_q;
    if (cpu_io_rd) io_rdata_d = rx_full_q ? {24'h0, rx_byte_q} : 32'h0;

    out_valid_d = cpu_io_wr;
    out_data_d  = cpu_io_wr ? bus.cpu_wdata[7:0] : out_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= 8'd0;
      rx_full_q   <= 1'b0;
      rx_byte_q   <= 8'h0;
      out_data_q  <= 8'h0;
      out_valid_q <= 1'b0;
      src_io_q    <= 1'b0;
      io_rdata_q  <= 32'h0;
    end else begin
      cnt_q       <= cnt_d;
      rx_full_q   <= rx_full_d;
      rx_byte_q   <= rx_byte_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      src_io_q    <= src_io_d;
      io_rdata_q  <= io_rdata_d;
    end
  end

  assign bus.mem_ren      = mem_ren;
  assign bus.mem_wen      = mem_wen;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.cpu_rdata    = src_io_q ? io_rdata_q : bus.mem_rdata;
  assign bus.cpu_hold     = (cnt_q >= HOLD_LIMIT) & ~gnt;
  assign bus.ldr_gnt      = gnt;
  assign bus.ldr_rvalid   = rvalid;
  assign bus.ldr_rdata    = bus.mem_rdata;
  assign bus.io_in_ready  = ~rx_full_q;
  assign bus.io_out_data  = out_data_q;
  assign bus.io_out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mic1_mem_arbiter.sv
// Directed-vector bench for mic1_mem_arbiter with a one-cycle-latency memory model.
`default_nettype none

module tb_mic1_mem_arbiter;

  localparam logic        H   = 1'b1;
  localparam logic        L   = 1'b0;
  localparam logic [31:0] Z   = 32'h0;
  localparam logic [7:0]  B0  = 8'h0;
  localparam logic [31:0] IOA = 32'hFFFF_FFFD;
  localparam logic [31:0] CB  = 32'hCAFE_BABE;
  localparam logic [31:0] R2  = 32'h1111_2222;
  localparam logic [31:0] BF  = 32'h0000_BEEF;
  localparam int          NV  = 31;

  typedef struct {
    logic        run, rd, wr;
    logic [31:0] addr, wdata;
    logic        iv;
    logic [7:0]  idata;
    logic        lreq, lwr;
    logic [31:0] laddr, lwdata;
    logic        e_ren, e_wen;
    logic [31:0] e_maddr;
    logic        e_ready, e_gnt, e_rv, e_hold;
    logic [31:0] e_rdata;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [31:0] e_lrd;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  mic1_mem_arbiter_if bus();

  mic1_mem_arbiter #(.IO_ADDR(IOA), .STARVE_LIMIT(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  logic [31:0] mrd = 32'h0;
  assign bus.mem_rdata = mrd;

  always @(posedge clk) begin
    if (bus.mem_ren) mrd <= mem[bus.mem_addr[9:2]];
    if (bus.mem_wen) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    bus.cpu_run     = v.run;
    bus.cpu_read    = v.rd;
    bus.cpu_write   = v.wr;
    bus.cpu_addr    = v.addr;
    bus.cpu_wdata   = v.wdata;
    bus.io_in_valid = v.iv;
    bus.io_in_data  = v.idata;
    bus.ldr_req     = v.lreq;
    bus.ldr_write   = v.lwr;
    bus.ldr_addr    = v.laddr;
    bus.ldr_wdata   = v.lwdata;
  endtask

  vec_t tv [NV];
  vec_t idle_v;

  initial begin
    idle_v = '{L,L,L,Z,Z, L,B0, L,L,Z,Z, L,L,Z,H,L,L,L, Z, L,B0, Z};
    tv[0]  = '{L,L,L,Z,Z, L,B0, L,L,Z,Z, L,L,Z,H,L,L,L, Z, L,B0, Z};
    tv[1]  = '{H,L,H,32'h10,CB, L,B0, L,L,Z,Z, L,H,32'h10,H,L,L,L, Z, L,B0, Z};
    tv[2]  = '{H,H,L,32'h10,Z, L,B0, L,L,Z,Z, H,L,32'h10,H,L,L,L, Z, L,B0, Z};
    tv[3]  = '{L,L,L,Z,Z, H,8'h33, L,L,Z,Z, L,L,Z,H,L,L,L, CB, L,B0, Z};
    tv[4]  = '{H,H,L,IOA,Z, L,B0, L,L,Z,Z, L,L,IOA,L,L,L,L, CB, L,B0, Z};
    tv[5]  = '{H,H,L,IOA,Z, L,B0, L,L,Z,Z, L,L,IOA,H,L,L,L, 32'h33, L,B0, Z};
    tv[6]  = '{H,L,H,IOA,32'h1234_560A, L,B0, L,L,Z,Z, L,L,IOA,H,L,L,L, Z, L,B0, Z};
    tv[7]  = '{H,L,H,IOA,32'h55, L,B0, L,L,Z,Z, L,L,IOA,H,L,L,L, CB, H,8'h0A, Z};
    tv[8]  = '{H,H,H,32'h10,R2, L,B0, L,L,Z,Z, H,H,32'h10,H,L,L,L, CB, H,8'h55, Z};
    tv[9]  = '{H,H,L,32'h10,Z, L,B0, L,L,Z,Z, H,L,32'h10,H,L,L,L, CB, L,8'h55, Z};
    tv[10] = '{L,L,L,Z,Z, L,B0, H,H,32'h40,BF, L,L,Z,H,L,L,L, R2, L,8'h55, Z};
    tv[11] = '{L,L,L,Z,Z, L,B0, H,H,32'h40,BF, L,H,32'h40,H,H,L,L, R2, L,8'h55, Z};
    tv[12] = '{L,L,L,Z,Z, L,B0, H,L,32'h40,Z, L,L,Z,H,L,L,L, R2, L,8'h55, Z};
    tv[13] = '{L,L,L,Z,Z, L,B0, H,L,32'h40,Z, H,L,32'h40,H,H,L,L, R2, L,8'h55, Z};
    tv[14] = '{H,H,L,32'h10,Z, L,B0, L,L,Z,Z, H,L,32'h10,H,L,H,L, BF, L,8'h55, BF};
    tv[15] = '{L,L,L,Z,Z, L,B0, L,L,Z,Z, L,L,Z,H,L,L,L, R2, L,8'h55, Z};
    for (int i = 16; i <= 20; i++)
      tv[i] = '{H,H,L,32'h10,Z, L,B0, H,H,32'h44,32'h77, H,L,32'h10,H,L,L,L, R2, L,8'h55, Z};
    tv[21] = '{H,H,L,32'h10,Z, L,B0, H,H,32'h44,32'h77, H,L,32'h10,H,L,L,H, R2, L,8'h55, Z};
    tv[22] = '{L,L,L,Z,Z, L,B0, H,H,32'h44,32'h77, L,H,32'h44,H,H,L,L, R2, L,8'h55, Z};
    tv[23] = '{L,L,L,Z,Z, L,B0, L,L,Z,Z, L,L,Z,H,L,L,L, R2, L,8'h55, Z};
    tv[24] = '{H,H,L,32'h10,Z, L,B0, H,L,32'h40,Z, H,L,32'h10,H,L,L,L, R2, L,8'h55, Z};
    tv[25] = '{H,H,L,32'h10,Z, L,B0, H,L,32'h40,Z, H,L,32'h10,H,L,L,L, R2, L,8'h55, Z};
    tv[26] = '{L,L,L,Z,Z, L,B0, L,L,Z,Z, L,L,Z,H,L,L,L, R2, L,8'h55, Z};
    tv[27] = '{L,L,L,Z,Z, L,B0, L,L,Z,Z, L,L,Z,H,L,L,L, R2, L,8'h55, Z};
    tv[28] = '{L,L,L,Z,Z, L,B0, H,H,IOA,32'h99, L,L,Z,H,L,L,L, R2, L,8'h55, Z};
    tv[29] = '{L,L,L,Z,Z, L,B0, H,H,IOA,32'h99, L,H,IOA,H,H,L,L, R2, L,8'h55, Z};
    tv[30] = '{L,L,L,Z,Z, L,B0, L,L,Z,Z, L,L,Z,H,L,L,L, R2, L,8'h55, Z};

    drive(idle_v);
    repeat (2) @(negedge clk);
    chk("rst_gnt",    bus.ldr_gnt,      0);
    chk("rst_rvalid", bus.ldr_rvalid,   0);
    chk("rst_hold",   bus.cpu_hold,     0);
    chk("rst_ov",     bus.io_out_valid, 0);
    chk("rst_od",     bus.io_out_data,  0);
    chk("rst_ready",  bus.io_in_ready,  1);
    chk("rst_ren",    bus.mem_ren,      0);
    chk("rst_wen",    bus.mem_wen,      0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d_ren", i),   bus.mem_ren,      tv[i].e_ren);
      chk($sformatf("v%0d_wen", i),   bus.mem_wen,      tv[i].e_wen);
      chk($sformatf("v%0d_maddr", i), bus.mem_addr,     tv[i].e_maddr);
      chk($sformatf("v%0d_ready", i), bus.io_in_ready,  tv[i].e_ready);
      chk($sformatf("v%0d_gnt", i),   bus.ldr_gnt,      tv[i].e_gnt);
      chk($sformatf("v%0d_rvalid", i),bus.ldr_rvalid,   tv[i].e_rv);
      chk($sformatf("v%0d_hold", i),  bus.cpu_hold,     tv[i].e_hold);
      chk($sformatf("v%0d_rdata", i), bus.cpu_rdata,    tv[i].e_rdata);
      chk($sformatf("v%0d_ov", i),    bus.io_out_valid, tv[i].e_ov);
      chk($sformatf("v%0d_od", i),    bus.io_out_data,  tv[i].e_od);
      if (tv[i].e_rv)
        chk($sformatf("v%0d_lrdata", i), bus.ldr_rdata, tv[i].e_lrd);
    end

    // Fill rx buffer and output register, then reset in the middle of a loader read response.
    @(negedge clk);
    drive('{H,L,H,IOA,32'hA5, H,8'h5A, L,L,Z,Z, L,L,Z,H,L,L,L, Z, L,B0, Z});
    @(negedge clk);
    drive('{L,L,L,Z,Z, L,B0, H,L,32'h44,Z, L,L,Z,H,L,L,L, Z, L,B0, Z});
    #1;
    chk("s_ready_full", bus.io_in_ready,  0);
    chk("s_ov",         bus.io_out_valid, 1);
    chk("s_od",         bus.io_out_data,  8'hA5);
    @(negedge clk);
    #1;
    chk("s_gnt", bus.ldr_gnt,  1);
    chk("s_ren", bus.mem_ren,  1);
    chk("s_maddr", bus.mem_addr, 32'h44);
    @(negedge clk);
    drive(idle_v);
    #1;
    chk("s_rvalid", bus.ldr_rvalid, 1);
    chk("s_lrdata", bus.ldr_rdata,  32'h77);
    #2 reset = 1'b1;
    #1;
    chk("r_rvalid", bus.ldr_rvalid,   0);
    chk("r_gnt",    bus.ldr_gnt,      0);
    chk("r_ready",  bus.io_in_ready,  1);
    chk("r_ov",     bus.io_out_valid, 0);
    chk("r_od",     bus.io_out_data,  0);
    chk("r_hold",   bus.cpu_hold,     0);
    chk("r_rdata",  bus.cpu_rdata,    32'h77);
    @(negedge clk);
    reset = 1'b0;
    drive('{H,H,L,32'h10,Z, L,B0, L,L,Z,Z, H,L,32'h10,H,L,L,L, Z, L,B0, Z});
    #1;
    chk("p_rvalid", bus.ldr_rvalid, 0);
    chk("p_ren",    bus.mem_ren,    1);
    @(negedge clk);
    drive(idle_v);
    #1;
    chk("p_rdata",   bus.cpu_rdata,  R2);
    chk("p_rvalid1", bus.ldr_rvalid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("p_rvalid_%0d", k), bus.ldr_rvalid, 0);
      chk($sformatf("p_gnt_%0d", k),    bus.ldr_gnt,    0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mic1_mem_arbiter.md
MIC1_MEM_ARBITER -- requirements
Module: mic1_mem_arbiter

Interface
REQ-001 SHALL have parameter IO_ADDR, default 32'hFFFF_FFFD, memory-mapped byte I/O address.
REQ-002 SHALL have parameter STARVE_LIMIT, default 16, loader wait cycles before cpu_hold asserts (range 1-255).
REQ-003 SHALL have ports: clk in 1, sole clock, all state on rising edge; reset in 1, asynchronous, active-high.
REQ-004 SHALL have CPU ports: cpu_run in 1; cpu_read in 1; cpu_write in 1; cpu_addr in 32; cpu_wdata in 32; cpu_rdata out 32; cpu_hold out 1 (request to gate run).
REQ-005 SHALL have loader ports: ldr_req in 1; ldr_write in 1; ldr_addr in 32; ldr_wdata in 32; ldr_gnt out 1; ldr_rvalid out 1; ldr_rdata out 32.
REQ-006 SHALL have memory ports: mem_ren out 1; mem_wen out 1; mem_addr out 32; mem_wdata out 32; mem_rdata in 32 (valid one cycle after mem_ren).
REQ-007 SHALL have I/O ports: io_in_data in 8; io_in_valid in 1; io_in_ready out 1; io_out_data out 8; io_out_valid out 1.

Function
REQ-008 CPU memory access = cpu_run & (cpu_read | cpu_write) & cpu_addr != IO_ADDR; it SHALL drive mem_* combinationally in the same cycle, zero added latency, absolute priority.
REQ-009 CPU read and write asserted together SHALL pass both to memory unchanged.
REQ-010 CPU access to IO_ADDR SHALL never assert mem_ren/mem_wen.
REQ-011 cpu_rdata SHALL be selected by a registered source flag: memory read -> mem_rdata; IO read -> {24'h0, rx_byte} if rx_full else 32'h0; otherwise mem_rdata.
REQ-012 Input buffer: one byte plus rx_full; io_in_ready = !rx_full; byte captured when io_in_valid & io_in_ready.
REQ-013 CPU read of IO_ADDR (cpu_run=1) SHALL clear rx_full at the clock edge; new byte accepted earliest next cycle.
REQ-014 CPU write of IO_ADDR (cpu_run=1) SHALL register io_out_data <= cpu_wdata[7:0] and pulse io_out_valid high exactly one cycle; back-to-back writes give consecutive pulses.
REQ-015 Loader FSM states: L_IDLE, L_WAIT, L_RESP.
REQ-016 L_IDLE: ldr_req=1 -> L_WAIT.
REQ-017 L_WAIT: cycle with no CPU memory access -> mem_* driven from ldr_* (mem_wen=ldr_write, mem_ren=!ldr_write), ldr_gnt=1 that cycle; next state L_RESP if read, else L_IDLE.
REQ-018 L_RESP: ldr_rvalid=1, ldr_rdata=mem_rdata for one cycle -> L_IDLE; CPU accesses in this cycle are unaffected.
REQ-019 Loader SHALL hold ldr_req, ldr_write, ldr_addr, ldr_wdata stable until ldr_gnt; ldr_req deasserted in L_WAIT before grant -> L_IDLE, no access.
REQ-020 Wait counter (8-bit, saturating at 255) SHALL count cycles in L_WAIT; cpu_hold=1 when counter >= STARVE_LIMIT; counter and cpu_hold clear in the grant cycle.
REQ-021 cpu_hold SHALL NOT grant anything itself; CPU accesses during hold keep priority.
REQ-022 Loader addresses SHALL NOT be IO-decoded; IO_ADDR from loader goes to memory.
REQ-023 No access: mem_ren=mem_wen=0; mem_addr/mem_wdata follow CPU inputs.

Reset
REQ-024 reset=1 SHALL immediately force: FSM L_IDLE, counter 0, rx_full 0, rx_byte 0, io_out_data 0, io_out_valid 0, ldr_gnt 0, ldr_rvalid 0, cpu_hold 0, source flag memory.
REQ-025 Reset mid-loader-transaction SHALL drop it; no ldr_rvalid after release.
REQ-026 First edge after reset release SHALL operate normally.

Verification
REQ-027 CPU read addr 0x10, memory holds 0xCAFEBABE -> mem_ren same cycle, cpu_rdata=0xCAFEBABE next cycle.
REQ-028 io_in_data=0x33 valid -> io_in_ready=0; CPU read IO_ADDR -> cpu_rdata=0x00000033 next cycle, rx_full=0, no mem_ren; second read -> 0x0.
REQ-029 CPU write IO_ADDR wdata 0x1234_560A -> io_out_data=0x0A, io_out_valid high one cycle, mem_wen=0.
REQ-030 Loader write 0x40<-0x0000BEEF with cpu_run=0 -> ldr_gnt next cycle, mem_wen=1 addr 0x40; later loader read 0x40 -> ldr_rvalid with 0x0000BEEF.
REQ-031 CPU reads every cycle, loader req pending, STARVE_LIMIT=4 -> cpu_hold after 4 wait cycles; CPU idles one cycle -> ldr_gnt, cpu_hold drops.
REQ-032 Reset asserted in L_RESP -> ldr_rvalid low immediately, FSM L_IDLE, no response after release.
